// File: rtl/dreg_arb_pkg.sv
// Shared definitions for the round-robin D-register write arbiter.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
// Contents: FSM state encoding, rotating-priority search function.
package dreg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    // Widest requester vector the search function handles.
    localparam int unsigned MAXREQ = 8;

    // Returns the index of the first set bit of req, scanning from ptr
    // upward and wrapping at n. Assumes ptr < n and n <= MAXREQ.
    // The caller checks that req is non-zero; with no request the
    // result is 0 and unused.
    function automatic int unsigned rr_pick(
        input logic [MAXREQ-1:0] req,
        input logic [2:0]        ptr,
        input int unsigned       n
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAXREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && !found && req[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dreg_write_arbiter_shared_dreg.sv
// Shared WIDTH-bit state register with load enable.
// Latency: d appears on q one clock after en is sampled high.
// Backpressure: none; loads whenever en is high, reset takes priority.
// Ports: clk, reset (sync, active-high), en, d, q.
module shared_dreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dreg_write_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one shared register.
// Latency: req sampled at t0, q updated at t1, ack pulsed t1..t2; one write per 3 cycles.
// Backpressure: requesters hold req until ack; en low blocks only new grants.
// Ports: clk, reset (sync, active-high), en, req[NREQ], wdata[NREQ*WIDTH],
//        gnt/ack (one-hot), q (register contents), busy, last_id.
module dreg_write_arbiter
    import dreg_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic [IDW-1:0]        last_id
);

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [IDW-1:0]  LAST_IDX = IDW'(NREQ - 1);

    state_e           state_q;
    logic [IDW-1:0]   sel_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   last_id_q;
    logic [WIDTH-1:0] hold_q;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  ack_q;
    logic             busy_q;

    logic [IDW-1:0]   winner_d;
    logic [IDW-1:0]   ptr_d;
    logic             reg_en;

    // Winner of the rotating search; only consumed in IDLE with req != 0.
    assign winner_d = IDW'(rr_pick(8'(req), 3'(ptr_q), NREQ));

    // The winner just served drops to lowest priority.
    assign ptr_d = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

    // Register enable decoded from registered state: one cycle, in WRITE.
    assign reg_en = (state_q == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            last_id_q <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && (|req)) begin
                        // Data is captured here so later wdata/req changes
                        // cannot disturb the in-flight write.
                        sel_q   <= winner_d;
                        hold_q  <= wdata[winner_d*WIDTH +: WIDTH];
                        gnt_q   <= ONE_HOT0 << winner_d;
                        busy_q  <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    gnt_q   <= '0;
                    ack_q   <= gnt_q;
                    state_q <= ACK;
                end
                ACK: begin
                    ack_q     <= '0;
                    busy_q    <= 1'b0;
                    ptr_q     <= ptr_d;
                    last_id_q <= sel_q;
                    state_q   <= IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    shared_dreg #(
        .WIDTH (WIDTH)
    ) u_shared_dreg (
        .clk   (clk),
        .reset (reset),
        .en    (reg_en),
        .d     (hold_q),
        .q     (q)
    );

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign last_id = last_id_q;

endmodule

// File: tb/tb_dreg_write_arbiter.sv
module tb_dreg_write_arbiter;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    logic [1:0]  last_id;

    int passed;
    int total;

    dreg_write_arbiter #(
        .NREQ  (4),
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .busy    (busy),
        .last_id (last_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    // Advance one rising edge, return at the following falling edge.
    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        en    = 1'b1;
        req   = 4'b1111;
        wdata = 32'h4433_2211;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++; if (q !== 8'h00) $display("FAIL rst_q: got %h want 00", q); else passed++;
            total++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt); else passed++;
            total++; if (ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", ack); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
            total++; if (last_id !== 2'd0) $display("FAIL rst_last_id: got %0d want 0", last_id); else passed++;
        end
        reset = 1'b0;
        req   = 4'b0000;
    endtask

    task automatic test_single_write;
        en          = 1'b1;
        wdata[7:0]  = 8'hA5;
        req         = 4'b0001;
        cyc();
        total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_w: got %b want 1", busy); else passed++;
        total++; if (q !== 8'h00) $display("FAIL single_q_early: got %h want 00", q); else passed++;
        total++; if (ack !== 4'b0000) $display("FAIL single_ack_early: got %b want 0000", ack); else passed++;
        cyc();
        total++; if (q !== 8'hA5) $display("FAIL single_q: got %h want a5", q); else passed++;
        total++; if (ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", ack); else passed++;
        total++; if (gnt !== 4'b0000) $display("FAIL single_gnt_off: got %b want 0000", gnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_a: got %b want 1", busy); else passed++;
        cyc();
        total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passed++;
        total++; if (ack !== 4'b0000) $display("FAIL single_ack_end: got %b want 0000", ack); else passed++;
        total++; if (last_id !== 2'd0) $display("FAIL single_last_id: got %0d want 0", last_id); else passed++;
        req = 4'b0000;
    endtask

    task automatic test_round_robin;
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] qexp  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [3:0] oh;
        int         dropped;
        dropped = -1;
        // Restart from ptr=0 so the service order begins at requester 0.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wdata = 32'h4433_2211;
        req   = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << order[j];
            cyc();
            total++; if (gnt !== oh) $display("FAIL rr_gnt%0d: got %b want %b", j, gnt, oh); else passed++;
            if (dropped >= 0) req[dropped] = 1'b1;
            cyc();
            total++; if (ack !== oh) $display("FAIL rr_ack%0d: got %b want %b", j, ack, oh); else passed++;
            total++; if (q !== qexp[j]) $display("FAIL rr_q%0d: got %h want %h", j, q, qexp[j]); else passed++;
            cyc();
            total++; if (busy !== 1'b0) $display("FAIL rr_idle%0d: got busy %b want 0", j, busy); else passed++;
            req[order[j]] = 1'b0;
            dropped = order[j];
        end
        req = 4'b0000;
    endtask

    task automatic test_enable_gate;
        en           = 1'b0;
        wdata[23:16] = 8'h5C;
        req          = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++; if (gnt !== 4'b0000) $display("FAIL en_gnt%0d: got %b want 0000", i, gnt); else passed++;
            total++; if (q !== 8'h11) $display("FAIL en_q%0d: got %h want 11", i, q); else passed++;
        end
        en = 1'b1;
        cyc();
        total++; if (gnt !== 4'b0100) $display("FAIL en_gnt_on: got %b want 0100", gnt); else passed++;
        cyc();
        total++; if (q !== 8'h5C) $display("FAIL en_q_on: got %h want 5c", q); else passed++;
        total++; if (ack !== 4'b0100) $display("FAIL en_ack: got %b want 0100", ack); else passed++;
        cyc();
        total++; if (last_id !== 2'd2) $display("FAIL en_last_id: got %0d want 2", last_id); else passed++;
        req = 4'b0000;
    endtask

    task automatic test_ptr_wrap;
        wdata[7:0]   = 8'h0A;
        wdata[23:16] = 8'h2B;
        req          = 4'b0101;
        cyc();
        total++; if (gnt !== 4'b0001) $display("FAIL wrap_gnt0: got %b want 0001", gnt); else passed++;
        cyc();
        total++; if (q !== 8'h0A) $display("FAIL wrap_q0: got %h want 0a", q); else passed++;
        total++; if (ack !== 4'b0001) $display("FAIL wrap_ack0: got %b want 0001", ack); else passed++;
        cyc();
        total++; if (last_id !== 2'd0) $display("FAIL wrap_last0: got %0d want 0", last_id); else passed++;
        req = 4'b0100;
        cyc();
        total++; if (gnt !== 4'b0100) $display("FAIL wrap_gnt2: got %b want 0100", gnt); else passed++;
        cyc();
        total++; if (q !== 8'h2B) $display("FAIL wrap_q2: got %h want 2b", q); else passed++;
        total++; if (ack !== 4'b0100) $display("FAIL wrap_ack2: got %b want 0100", ack); else passed++;
        cyc();
        total++; if (last_id !== 2'd2) $display("FAIL wrap_last2: got %0d want 2", last_id); else passed++;
        req = 4'b0000;
    endtask

    task automatic test_reset_in_write;
        wdata[7:0]  = 8'h77;
        wdata[15:8] = 8'h66;
        req         = 4'b0010;
        cyc();
        total++; if (gnt !== 4'b0010) $display("FAIL midrst_gnt: got %b want 0010", gnt); else passed++;
        reset = 1'b1;
        req   = 4'b0011;
        cyc();
        total++; if (q !== 8'h00) $display("FAIL midrst_q: got %h want 00", q); else passed++;
        total++; if (gnt !== 4'b0000) $display("FAIL midrst_gnt_off: got %b want 0000", gnt); else passed++;
        total++; if (ack !== 4'b0000) $display("FAIL midrst_ack: got %b want 0000", ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        total++; if (last_id !== 2'd0) $display("FAIL midrst_last_id: got %0d want 0", last_id); else passed++;
        reset = 1'b0;
        cyc();
        total++; if (gnt !== 4'b0001) $display("FAIL midrst_next_gnt: got %b want 0001", gnt); else passed++;
        total++; if (ack !== 4'b0000) $display("FAIL midrst_no_ack: got %b want 0000", ack); else passed++;
        cyc();
        total++; if (ack !== 4'b0001) $display("FAIL midrst_next_ack: got %b want 0001", ack); else passed++;
        total++; if (q !== 8'h77) $display("FAIL midrst_next_q: got %h want 77", q); else passed++;
        cyc();
        req = 4'b0000;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        en     = 1'b0;
        req    = 4'b0000;
        wdata  = 32'h0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_enable_gate();
        test_ptr_wrap();
        test_reset_in_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
